// File: rtl/wb_stage_if.sv
// Bus bundle between the MEM stage, wb_stage and the regfile write port.
// The master side (MEM stage / bench) drives the in_* fields, stall and flush.
// The slave side (wb_stage) drives the regfile port, forwarding tap and counters.
interface wb_stage_if #(
  parameter int BITS      = 32,
  parameter int WORDS     = 32,
  parameter int ADDR_LEFT = $clog2(WORDS) - 1
);

  // pipeline control
  logic                 stall;
  logic                 flush;

  // retiring instruction from MEM
  logic                 in_valid;
  logic                 in_reg_write;
  logic                 in_mem_to_reg;
  logic [1:0]           in_load_size;
  logic                 in_load_uns;
  logic [1:0]           in_byte_off;
  logic [ADDR_LEFT:0]   in_waddr;
  logic [BITS-1:0]      in_alu_result;
  logic [BITS-1:0]      in_mem_rdata;
  logic                 in_jal;
  logic [BITS-1:0]      in_pc_addr;

  // regfile write port
  logic                 rw_;
  logic [ADDR_LEFT:0]   waddr;
  logic [BITS-1:0]      wdata;
  logic [3:0]           byte_en;
  logic                 jal;
  logic [BITS-1:0]      pc_addr;

  // EX bypass tap and status
  logic                 fwd_valid;
  logic [ADDR_LEFT:0]   fwd_addr;
  logic [BITS-1:0]      fwd_data;
  logic                 align_err;
  logic [BITS-1:0]      retire_count;

  modport master (
    output stall, flush,
    output in_valid, in_reg_write, in_mem_to_reg, in_load_size, in_load_uns,
    output in_byte_off, in_waddr, in_alu_result, in_mem_rdata, in_jal, in_pc_addr,
    input  rw_, waddr, wdata, byte_en, jal, pc_addr,
    input  fwd_valid, fwd_addr, fwd_data, align_err, retire_count
  );

  modport slave (
    input  stall, flush,
    input  in_valid, in_reg_write, in_mem_to_reg, in_load_size, in_load_uns,
    input  in_byte_off, in_waddr, in_alu_result, in_mem_rdata, in_jal, in_pc_addr,
    output rw_, waddr, wdata, byte_en, jal, pc_addr,
    output fwd_valid, fwd_addr, fwd_data, align_err, retire_count
  );

endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register plus writeback formatter feeding the regfile.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_EMPTY  | no instruction held (bubble, flushed, or after reset)
// ST_LIVE   | instruction held, first cycle: writes regfile and retires
// ST_DONE   | same instruction held under stall, already written/retired
//
// Outputs are purely combinational from the captured fields, so an
// instruction reaches the regfile port one edge after MEM presents it.
module wb_stage #(
  parameter int BITS      = 32,
  parameter int WORDS     = 32,
  parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
  input logic     clk,
  input logic     rst,
  wb_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_LIVE  = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [1:0]         SZ_BYTE  = 2'b01;
  localparam logic [1:0]         SZ_HALF  = 2'b10;
  localparam logic [ADDR_LEFT:0] LINK_REG = (ADDR_LEFT + 1)'(31);
  localparam logic [BITS-1:0]    ONE      = BITS'(1);

  state_t               state_q, state_d;
  logic                 reg_write_q, reg_write_d;
  logic                 mem_to_reg_q, mem_to_reg_d;
  logic [1:0]           load_size_q, load_size_d;
  logic                 load_uns_q, load_uns_d;
  logic [1:0]           byte_off_q, byte_off_d;
  logic [ADDR_LEFT:0]   waddr_q, waddr_d;
  logic [BITS-1:0]      alu_q, alu_d;
  logic [BITS-1:0]      rdata_q, rdata_d;
  logic                 jal_q, jal_d;
  logic [BITS-1:0]      pc_q, pc_d;
  logic [BITS-1:0]      retire_q, retire_d;

  logic                 valid_q;
  logic                 first_q;
  logic                 misalign;
  logic [7:0]           lane_b;
  logic [15:0]          lane_h;
  logic [BITS-1:0]      load_data;
  logic [3:0]           load_be;
  logic [BITS-1:0]      result;
  logic [3:0]           result_be;
  logic [ADDR_LEFT:0]   fwd_addr;
  logic                 wr_ok;

  // Held instruction exists; first_q marks its single write/retire cycle.
  assign valid_q = (state_q != ST_EMPTY);
  assign first_q = (state_q == ST_LIVE);

  // State register and captured instruction fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_size_q  <= 2'b00;
      load_uns_q   <= 1'b0;
      byte_off_q   <= 2'b00;
      waddr_q      <= '0;
      alu_q        <= '0;
      rdata_q      <= '0;
      jal_q        <= 1'b0;
      pc_q         <= '0;
      retire_q     <= '0;
    end else begin
      state_q      <= state_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      load_size_q  <= load_size_d;
      load_uns_q   <= load_uns_d;
      byte_off_q   <= byte_off_d;
      waddr_q      <= waddr_d;
      alu_q        <= alu_d;
      rdata_q      <= rdata_d;
      jal_q        <= jal_d;
      pc_q         <= pc_d;
      retire_q     <= retire_d;
    end
  end

  // Next state: flush wins over stall; a stall freezes the fields and moves
  // a live instruction to DONE so it never writes or retires twice.
  always_comb begin
    state_d      = state_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    load_size_d  = load_size_q;
    load_uns_d   = load_uns_q;
    byte_off_d   = byte_off_q;
    waddr_d      = waddr_q;
    alu_d        = alu_q;
    rdata_d      = rdata_q;
    jal_d        = jal_q;
    pc_d         = pc_q;

    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else if (!bus.stall) begin
      state_d      = bus.in_valid ? ST_LIVE : ST_EMPTY;
      reg_write_d  = bus.in_reg_write;
      mem_to_reg_d = bus.in_mem_to_reg;
      load_size_d  = bus.in_load_size;
      load_uns_d   = bus.in_load_uns;
      byte_off_d   = bus.in_byte_off;
      waddr_d      = bus.in_waddr;
      alu_d        = bus.in_alu_result;
      rdata_d      = bus.in_mem_rdata;
      jal_d        = bus.in_jal;
      pc_d         = bus.in_pc_addr;
    end else begin
      case (state_q)
        ST_LIVE:  state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Retire counter: one count per instruction on its first held cycle, wraps.
  always_comb begin
    retire_d = retire_q;
    if (first_q) begin
      retire_d = retire_q + ONE;
    end
  end

  // Lane selection from the raw memory word.
  always_comb begin
    lane_b = rdata_q[7:0];
    case (byte_off_q)
      2'd1:    lane_b = rdata_q[15:8];
      2'd2:    lane_b = rdata_q[23:16];
      2'd3:    lane_b = rdata_q[31:24];
      default: lane_b = rdata_q[7:0];
    endcase
    lane_h = byte_off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  // Load formatting: signed loads sign-extend with full byte enables,
  // unsigned loads zero-extend and narrow the enables; size 11 acts as word.
  always_comb begin
    load_data = rdata_q;
    load_be   = 4'b1111;
    if (load_size_q == SZ_BYTE) begin
      if (load_uns_q) begin
        load_data = {{(BITS-8){1'b0}}, lane_b};
        load_be   = 4'b0001;
      end else begin
        load_data = {{(BITS-8){lane_b[7]}}, lane_b};
      end
    end else if (load_size_q == SZ_HALF) begin
      if (load_uns_q) begin
        load_data = {{(BITS-16){1'b0}}, lane_h};
        load_be   = 4'b0011;
      end else begin
        load_data = {{(BITS-16){lane_h[15]}}, lane_h};
      end
    end
  end

  // Result mux; odd-offset halfword loads are dropped rather than written.
  always_comb begin
    misalign  = mem_to_reg_q & (load_size_q == SZ_HALF) & byte_off_q[0];
    result    = mem_to_reg_q ? load_data : alu_q;
    result_be = mem_to_reg_q ? load_be : 4'b1111;
    fwd_addr  = jal_q ? LINK_REG : waddr_q;
    wr_ok     = first_q & reg_write_q & (|waddr_q) & ~misalign;
  end

  // Regfile port, bypass tap and status; a jal to r31 still requests the
  // normal write because the regfile resolves it in favour of the link.
  always_comb begin
    bus.rw_          = ~wr_ok;
    bus.waddr        = waddr_q;
    bus.wdata        = result;
    bus.byte_en      = result_be;
    bus.jal          = first_q & jal_q;
    bus.pc_addr      = pc_q;
    bus.fwd_valid    = valid_q & (reg_write_q | jal_q) & (|fwd_addr) & ~misalign;
    bus.fwd_addr     = fwd_addr;
    bus.fwd_data     = jal_q ? (pc_q + ONE) : result;
    bus.align_err    = first_q & misalign;
    bus.retire_count = retire_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run
// compared against an instruction-level reference model.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_stage_if bus ();

  wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        jal;
    logic [31:0] pc;
  } ins_t;

  // reference model: the instruction sitting in WB and whether it already retired
  ins_t        m_ins;
  bit          m_valid;
  bit          m_done;
  logic [31:0] m_count;

  ins_t cur_in;
  bit   cur_stall;
  bit   cur_flush;

  function automatic ins_t idle_ins();
    ins_t i = '0;
    return i;
  endfunction

  function automatic ins_t alu_ins(logic [4:0] wa, logic [31:0] val);
    ins_t i = '0;
    i.valid = 1; i.reg_write = 1; i.waddr = wa; i.alu = val;
    return i;
  endfunction

  function automatic ins_t load_ins(logic [4:0] wa, logic [1:0] sz, logic u, logic [1:0] o, logic [31:0] rd);
    ins_t i = '0;
    i.valid = 1; i.reg_write = 1; i.mem_to_reg = 1; i.waddr = wa;
    i.size = sz; i.uns = u; i.off = o; i.rdata = rd;
    return i;
  endfunction

  function automatic bit is_misaligned(ins_t i);
    return i.mem_to_reg && i.size == 2'b10 && i.off[0];
  endfunction

  function automatic logic [31:0] exp_wdata(ins_t i);
    logic [31:0] v;
    if (!i.mem_to_reg) return i.alu;
    if (i.size == 2'b01) begin
      v = (i.rdata >> (8 * int'(i.off))) & 32'h0000_00FF;
      if (!i.uns && v[7]) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (i.size == 2'b10) begin
      v = (i.rdata >> (16 * (int'(i.off) / 2))) & 32'h0000_FFFF;
      if (!i.uns && v[15]) v = v | 32'hFFFF_0000;
      return v;
    end
    return i.rdata;
  endfunction

  function automatic logic [3:0] exp_be(ins_t i);
    if (i.mem_to_reg && i.uns && i.size == 2'b01) return 4'b0001;
    if (i.mem_to_reg && i.uns && i.size == 2'b10) return 4'b0011;
    return 4'b1111;
  endfunction

  task automatic model_reset();
    m_ins = '0; m_valid = 0; m_done = 0; m_count = 0;
  endtask

  task automatic model_edge(ins_t in, bit stall, bit flush);
    if (m_valid && !m_done) m_count = m_count + 1;
    if (flush) begin
      m_valid = 0; m_done = 0;
    end else if (!stall) begin
      m_ins = in; m_valid = in.valid; m_done = 0;
    end else if (m_valid) begin
      m_done = 1;
    end
  endtask

  task automatic drive(ins_t in, bit stall, bit flush);
    cur_in = in; cur_stall = stall; cur_flush = flush;
    bus.stall         = stall;
    bus.flush         = flush;
    bus.in_valid      = in.valid;
    bus.in_reg_write  = in.reg_write;
    bus.in_mem_to_reg = in.mem_to_reg;
    bus.in_load_size  = in.size;
    bus.in_load_uns   = in.uns;
    bus.in_byte_off   = in.off;
    bus.in_waddr      = in.waddr;
    bus.in_alu_result = in.alu;
    bus.in_mem_rdata  = in.rdata;
    bus.in_jal        = in.jal;
    bus.in_pc_addr    = in.pc;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge(cur_in, cur_stall, cur_flush);
    #1;
  endtask

  task automatic apply_reset();
    drive(idle_ins(), 0, 0);
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.rw_ !== 1'b1) begin failures++; $display("FAIL reset_rw_ got=%b exp=1", bus.rw_); end
    checks++; if (bus.jal !== 1'b0) begin failures++; $display("FAIL reset_jal got=%b exp=0", bus.jal); end
    checks++; if (bus.byte_en !== 4'b1111) begin failures++; $display("FAIL reset_byte_en got=%b exp=1111", bus.byte_en); end
    checks++; if (bus.waddr !== 5'd0 || bus.wdata !== 32'd0 || bus.pc_addr !== 32'd0) begin
      failures++; $display("FAIL reset_port got waddr=%0d wdata=%h pc=%h exp all 0", bus.waddr, bus.wdata, bus.pc_addr);
    end
    checks++; if (bus.fwd_valid !== 1'b0 || bus.fwd_addr !== 5'd0 || bus.fwd_data !== 32'd0) begin
      failures++; $display("FAIL reset_fwd got v=%b a=%0d d=%h exp 0", bus.fwd_valid, bus.fwd_addr, bus.fwd_data);
    end
    checks++; if (bus.align_err !== 1'b0 || bus.retire_count !== 32'd0) begin
      failures++; $display("FAIL reset_status got align=%b count=%0d exp 0", bus.align_err, bus.retire_count);
    end
  endtask

  task automatic test_alu();
    drive(alu_ins(5'd5, 32'h1234), 0, 0);
    tick();
    drive(idle_ins(), 0, 0);
    checks++; if (bus.rw_ !== 1'b0) begin failures++; $display("FAIL alu_rw_ got=%b exp=0", bus.rw_); end
    checks++; if (bus.waddr !== 5'd5 || bus.wdata !== 32'h1234) begin
      failures++; $display("FAIL alu_write got waddr=%0d wdata=%h exp 5/00001234", bus.waddr, bus.wdata);
    end
    checks++; if (bus.byte_en !== 4'b1111) begin failures++; $display("FAIL alu_byte_en got=%b exp=1111", bus.byte_en); end
    tick();
    checks++; if (bus.retire_count !== 32'd1) begin failures++; $display("FAIL alu_count got=%0d exp=1", bus.retire_count); end
    checks++; if (bus.rw_ !== 1'b1) begin failures++; $display("FAIL alu_idle_rw_ got=%b exp=1", bus.rw_); end
  endtask

  task automatic test_loads();
    drive(load_ins(5'd6, 2'b01, 1'b0, 2'd3, 32'h80FF_0000), 0, 0);
    tick();
    checks++; if (bus.wdata !== 32'hFFFF_FF80 || bus.byte_en !== 4'b1111) begin
      failures++; $display("FAIL lb_off3 got wdata=%h be=%b exp ffffff80/1111", bus.wdata, bus.byte_en);
    end
    drive(load_ins(5'd7, 2'b10, 1'b1, 2'd2, 32'h80FF_0000), 0, 0);
    tick();
    checks++; if (bus.wdata !== 32'h0000_80FF || bus.byte_en !== 4'b0011) begin
      failures++; $display("FAIL lhu_off2 got wdata=%h be=%b exp 000080ff/0011", bus.wdata, bus.byte_en);
    end
    drive(load_ins(5'd8, 2'b01, 1'b1, 2'd1, 32'h1234_A5C3), 0, 0);
    tick();
    checks++; if (bus.wdata !== 32'h0000_00A5 || bus.byte_en !== 4'b0001) begin
      failures++; $display("FAIL lbu_off1 got wdata=%h be=%b exp 000000a5/0001", bus.wdata, bus.byte_en);
    end
    drive(idle_ins(), 0, 0);
    tick();
  endtask

  task automatic test_stall_once();
    int writes = 0;
    int fwds = 0;
    logic [31:0] base = m_count;
    drive(alu_ins(5'd9, 32'hCAFE_0009), 0, 0);
    tick();
    for (int c = 0; c < 4; c++) begin
      if (bus.rw_ === 1'b0) writes++;
      if (bus.fwd_valid === 1'b1) fwds++;
      drive(idle_ins(), c < 3, 0);
      tick();
    end
    checks++; if (writes != 1) begin failures++; $display("FAIL stall_single_write got=%0d exp=1", writes); end
    checks++; if (fwds != 4) begin failures++; $display("FAIL stall_fwd_held got=%0d exp=4", fwds); end
    checks++; if (bus.retire_count !== base + 32'd1) begin
      failures++; $display("FAIL stall_count got=%0d exp=%0d", bus.retire_count, base + 32'd1);
    end
  endtask

  task automatic test_jal();
    ins_t i = alu_ins(5'd31, 32'h0000_0777);
    i.jal = 1; i.pc = 32'h40;
    drive(i, 0, 0);
    tick();
    drive(idle_ins(), 0, 0);
    checks++; if (bus.jal !== 1'b1 || bus.pc_addr !== 32'h40) begin
      failures++; $display("FAIL jal_strobe got jal=%b pc=%h exp 1/00000040", bus.jal, bus.pc_addr);
    end
    checks++; if (bus.fwd_valid !== 1'b1 || bus.fwd_addr !== 5'd31 || bus.fwd_data !== 32'h41) begin
      failures++; $display("FAIL jal_fwd got v=%b a=%0d d=%h exp 1/31/00000041", bus.fwd_valid, bus.fwd_addr, bus.fwd_data);
    end
    checks++; if (bus.rw_ !== 1'b0) begin failures++; $display("FAIL jal_r31_write got rw_=%b exp=0", bus.rw_); end
    tick();
    checks++; if (bus.jal !== 1'b0) begin failures++; $display("FAIL jal_drop got=%b exp=0", bus.jal); end
  endtask

  task automatic test_misalign();
    drive(load_ins(5'd10, 2'b10, 1'b0, 2'd1, 32'h1122_3344), 0, 0);
    tick();
    checks++; if (bus.rw_ !== 1'b1 || bus.align_err !== 1'b1 || bus.fwd_valid !== 1'b0) begin
      failures++; $display("FAIL lh_off1 got rw_=%b align=%b fwd=%b exp 1/1/0", bus.rw_, bus.align_err, bus.fwd_valid);
    end
    drive(idle_ins(), 1, 0);
    tick();
    checks++; if (bus.align_err !== 1'b0) begin failures++; $display("FAIL align_pulse got=%b exp=0", bus.align_err); end
    drive(alu_ins(5'd0, 32'hDEAD_BEEF), 0, 0);
    tick();
    checks++; if (bus.rw_ !== 1'b1 || bus.fwd_valid !== 1'b0) begin
      failures++; $display("FAIL r0_write got rw_=%b fwd=%b exp 1/0", bus.rw_, bus.fwd_valid);
    end
    drive(idle_ins(), 0, 0);
    tick();
  endtask

  task automatic test_flush_and_reset();
    drive(alu_ins(5'd12, 32'h5555_0012), 0, 0);
    tick();
    drive(alu_ins(5'd13, 32'h5555_0013), 1, 1);
    tick();
    checks++; if (bus.rw_ !== 1'b1 || bus.fwd_valid !== 1'b0) begin
      failures++; $display("FAIL flush_over_stall got rw_=%b fwd=%b exp 1/0", bus.rw_, bus.fwd_valid);
    end
    drive(alu_ins(5'd14, 32'h5555_0014), 0, 0);
    tick();
    drive(idle_ins(), 1, 0);
    tick();
    #2;
    rst = 1;
    model_reset();
    #1;
    checks++; if (bus.rw_ !== 1'b1 || bus.fwd_valid !== 1'b0 || bus.retire_count !== 32'd0) begin
      failures++; $display("FAIL rst_mid_stall got rw_=%b fwd=%b count=%0d exp 1/0/0", bus.rw_, bus.fwd_valid, bus.retire_count);
    end
    checks++; if (bus.waddr !== 5'd0 || bus.wdata !== 32'd0 || bus.byte_en !== 4'b1111) begin
      failures++; $display("FAIL rst_mid_stall_port got waddr=%0d wdata=%h be=%b exp 0/0/1111", bus.waddr, bus.wdata, bus.byte_en);
    end
    drive(idle_ins(), 0, 0);
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  task automatic test_random();
    ins_t i;
    bit wr, mis;
    logic [31:0] e_wdata, e_fdata;
    logic [4:0]  e_faddr;
    for (int n = 0; n < 500; n++) begin
      i = '0;
      i.valid      = ($urandom_range(0, 9) < 8);
      i.reg_write  = ($urandom_range(0, 9) < 8);
      i.mem_to_reg = $urandom_range(0, 1);
      i.size       = 2'($urandom_range(0, 3));
      i.uns        = $urandom_range(0, 1);
      i.off        = 2'($urandom_range(0, 3));
      i.waddr      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      i.alu        = $urandom;
      i.rdata      = $urandom;
      i.jal        = ($urandom_range(0, 7) == 0);
      i.pc         = $urandom;
      drive(i, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      tick();
      mis     = m_valid && is_misaligned(m_ins);
      wr      = m_valid && !m_done && m_ins.reg_write && m_ins.waddr != 0 && !mis;
      e_wdata = exp_wdata(m_ins);
      e_faddr = m_ins.jal ? 5'd31 : m_ins.waddr;
      e_fdata = m_ins.jal ? m_ins.pc + 32'd1 : e_wdata;
      checks++; if (bus.rw_ !== !wr) begin failures++; $display("FAIL rnd_rw_ n=%0d got=%b exp=%b", n, bus.rw_, !wr); end
      checks++; if (bus.waddr !== m_ins.waddr || bus.wdata !== e_wdata || bus.byte_en !== exp_be(m_ins)) begin
        failures++; $display("FAIL rnd_port n=%0d got %0d/%h/%b exp %0d/%h/%b", n, bus.waddr, bus.wdata, bus.byte_en, m_ins.waddr, e_wdata, exp_be(m_ins));
      end
      checks++; if (bus.jal !== (m_valid && !m_done && m_ins.jal) || bus.pc_addr !== m_ins.pc) begin
        failures++; $display("FAIL rnd_jal n=%0d got %b/%h exp %b/%h", n, bus.jal, bus.pc_addr, m_valid && !m_done && m_ins.jal, m_ins.pc);
      end
      checks++; if (bus.fwd_valid !== (m_valid && (m_ins.reg_write || m_ins.jal) && e_faddr != 0 && !mis) ||
                    bus.fwd_addr !== e_faddr || bus.fwd_data !== e_fdata) begin
        failures++; $display("FAIL rnd_fwd n=%0d got %b/%0d/%h exp addr %0d data %h", n, bus.fwd_valid, bus.fwd_addr, bus.fwd_data, e_faddr, e_fdata);
      end
      checks++; if (bus.align_err !== (m_valid && !m_done && mis) || bus.retire_count !== m_count) begin
        failures++; $display("FAIL rnd_status n=%0d got align=%b count=%0d exp %b/%0d", n, bus.align_err, bus.retire_count, m_valid && !m_done && mis, m_count);
      end
    end
    drive(idle_ins(), 0, 0);
    tick();
  endtask

  initial begin
    drive(idle_ins(), 0, 0);
    model_reset();
    test_reset();
    test_alu();
    test_loads();
    test_stall_once();
    test_jal();
    test_misalign();
    test_flush_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
